// File: rtl/register_access_sequencer.sv
// register_access_sequencer: serialises register-bank writebacks and two-operand reads behind valid/ready handshakes
module register_access_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic        wbValid,
  output logic        wbReady,
  input  logic [3:0]  rd,
  input  logic [31:0] wbData,
  output logic        opValid,
  input  logic        opReady,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [3:0]  bankRegNum,
  output logic [31:0] bankDataIn,
  output logic        bankWriteEnable,
  input  logic [31:0] bankDataOut
);
  typedef enum logic [2:0] {IDLE, WRITE, READ1, READ2, CAPTURE, HOLD} state_t;
  state_t      state_q, state_d;
  logic [3:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] wd_q, wd_d, op1_q, op1_d, op2_q, op2_d;
  // State and latched request fields; reset clears everything without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wd_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      wd_q    <= wd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end
  // Next state; writeback has priority, bank read data arrives one cycle after its index, index 0 reads as zero
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    wd_d    = wd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    case (state_q)
      IDLE: begin
        if (wbValid) begin
          state_d = WRITE;
          rd_d    = rd;
          wd_d    = wbData;
        end else if (reqValid) begin
          state_d = READ1;
          rs1_d   = rs1;
          rs2_d   = rs2;
        end
      end
      WRITE:   state_d = IDLE;
      READ1:   state_d = READ2;
      READ2: begin
        op1_d   = (rs1_q == 4'd0) ? 32'h0 : bankDataOut;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        op2_d   = (rs2_q == 4'd0) ? 32'h0 : bankDataOut;
        state_d = HOLD;
      end
      HOLD:    state_d = opReady ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  assign reqReady        = (state_q == IDLE) && !wbValid;
  assign wbReady         = (state_q == IDLE);
  assign opValid         = (state_q == HOLD);
  assign op1             = op1_q;
  assign op2             = op2_q;
  assign bankWriteEnable = (state_q == WRITE) && (rd_q != 4'd0);
  assign bankDataIn      = (state_q == WRITE) ? wd_q : 32'h0;
  assign bankRegNum      = (state_q == WRITE) ? rd_q :
                           (state_q == READ1) ? rs1_q :
                           (state_q == READ2) ? rs2_q : 4'd0;
endmodule

// File: tb/tb_register_access_sequencer.sv
// tb_register_access_sequencer: directed checks of the sequencer against a one-cycle-latency bank model
module tb_register_access_sequencer;
  logic        clk = 0, reset = 1;
  logic        reqValid = 0, wbValid = 0, opReady = 0;
  logic [3:0]  rs1 = 0, rs2 = 0, rd = 0;
  logic [31:0] wbData = 0;
  logic        reqReady, wbReady, opValid, bankWriteEnable;
  logic [31:0] op1, op2, bankDataIn, bankDataOut;
  logic [3:0]  bankRegNum;
  logic [31:0] regs [16];
  int          errors = 0, checks = 0;

  register_access_sequencer dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .rs1(rs1), .rs2(rs2), .wbValid(wbValid), .wbReady(wbReady),
    .rd(rd), .wbData(wbData), .opValid(opValid), .opReady(opReady),
    .op1(op1), .op2(op2), .bankRegNum(bankRegNum), .bankDataIn(bankDataIn),
    .bankWriteEnable(bankWriteEnable), .bankDataOut(bankDataOut)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'hA5A50000 + i;
    regs[0] = 32'hF0F0F0F0;
    regs[3] = 32'h0;
    bankDataOut = 32'h0;
  end

  // Bank: synchronous write, registered read
  always @(posedge clk) begin
    if (bankWriteEnable) regs[bankRegNum] <= bankDataIn;
    bankDataOut <= regs[bankRegNum];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_opValid", {31'b0, opValid}, 0);
    chk("rst_bwe", {31'b0, bankWriteEnable}, 0);
    chk("rst_brn", {28'b0, bankRegNum}, 0);
    chk("rst_bdi", bankDataIn, 0);
    chk("rst_op1", op1, 0);
    #2 reset = 0;
    #1;
    chk("idle_reqReady", {31'b0, reqReady}, 1);
    chk("idle_wbReady", {31'b0, wbReady}, 1);
    // Writeback rd=5
    wbValid = 1; rd = 5; wbData = 32'hFFFFFFFF;
    #1;
    chk("wb_reqReady_blocked", {31'b0, reqReady}, 0);
    step();
    wbValid = 0;
    chk("wr_bwe", {31'b0, bankWriteEnable}, 1);
    chk("wr_brn", {28'b0, bankRegNum}, 5);
    chk("wr_bdi", bankDataIn, 32'hFFFFFFFF);
    chk("wr_wbReady", {31'b0, wbReady}, 0);
    step();
    chk("wr_done_bwe", {31'b0, bankWriteEnable}, 0);
    chk("wr_done_bdi", bankDataIn, 0);
    chk("bank_reg5", regs[5], 32'hFFFFFFFF);
    // Read rs1=5, rs2=3
    reqValid = 1; rs1 = 5; rs2 = 3;
    #1;
    chk("rd_reqReady", {31'b0, reqReady}, 1);
    step();
    reqValid = 0;
    chk("read1_brn", {28'b0, bankRegNum}, 5);
    chk("read1_bwe", {31'b0, bankWriteEnable}, 0);
    chk("read1_opValid", {31'b0, opValid}, 0);
    step();
    chk("read2_brn", {28'b0, bankRegNum}, 3);
    step();
    chk("capture_opValid", {31'b0, opValid}, 0);
    chk("capture_brn", {28'b0, bankRegNum}, 0);
    step();
    chk("hold_opValid", {31'b0, opValid}, 1);
    chk("hold_op1", op1, 32'hFFFFFFFF);
    chk("hold_op2", op2, 32'h0);
    opReady = 1;
    step();
    opReady = 0;
    chk("release_opValid", {31'b0, opValid}, 0);
    chk("release_wbReady", {31'b0, wbReady}, 1);
    // Collision: writeback wins, read follows
    wbValid = 1; rd = 7; wbData = 32'hF0F0F0F0;
    reqValid = 1; rs1 = 7; rs2 = 7;
    #1;
    chk("col_reqReady", {31'b0, reqReady}, 0);
    step();
    wbValid = 0;
    chk("col_wr_bwe", {31'b0, bankWriteEnable}, 1);
    chk("col_wr_brn", {28'b0, bankRegNum}, 7);
    chk("col_wr_reqReady", {31'b0, reqReady}, 0);
    step();
    chk("col_idle_reqReady", {31'b0, reqReady}, 1);
    step();
    reqValid = 0;
    chk("col_read1_brn", {28'b0, bankRegNum}, 7);
    repeat (3) step();
    chk("col_opValid", {31'b0, opValid}, 1);
    chk("col_op1", op1, 32'hF0F0F0F0);
    chk("col_op2", op2, 32'hF0F0F0F0);
    // Backpressure with pending requests held off
    reqValid = 1; rs1 = 1; rs2 = 2;
    wbValid = 1; rd = 4; wbData = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_opValid", {31'b0, opValid}, 1);
      chk("bp_op1", op1, 32'hF0F0F0F0);
      chk("bp_op2", op2, 32'hF0F0F0F0);
      chk("bp_reqReady", {31'b0, reqReady}, 0);
      chk("bp_wbReady", {31'b0, wbReady}, 0);
    end
    reqValid = 0; wbValid = 0;
    opReady = 1;
    step();
    opReady = 0;
    chk("bp_release_opValid", {31'b0, opValid}, 0);
    chk("bp_release_reqReady", {31'b0, reqReady}, 1);
    chk("bank_reg4_untouched", regs[4], 32'hA5A50004);
    // Zero register write is dropped
    wbValid = 1; rd = 0; wbData = 32'h12345678;
    step();
    wbValid = 0;
    chk("zero_wr_bwe", {31'b0, bankWriteEnable}, 0);
    chk("zero_wr_wbReady", {31'b0, wbReady}, 0);
    step();
    chk("bank_reg0", regs[0], 32'hF0F0F0F0);
    // Zero register reads as zero
    reqValid = 1; rs1 = 0; rs2 = 5;
    step();
    reqValid = 0;
    chk("zero_read1_brn", {28'b0, bankRegNum}, 0);
    repeat (3) step();
    chk("zero_opValid", {31'b0, opValid}, 1);
    chk("zero_op1", op1, 32'h0);
    chk("zero_op2", op2, 32'hFFFFFFFF);
    // Asynchronous reset in HOLD
    step();
    #2 reset = 1;
    #1;
    chk("arst_opValid", {31'b0, opValid}, 0);
    chk("arst_op1", op1, 0);
    chk("arst_op2", op2, 0);
    chk("arst_bwe", {31'b0, bankWriteEnable}, 0);
    step();
    reset = 0;
    #1;
    chk("arst_rel_reqReady", {31'b0, reqReady}, 1);
    chk("arst_rel_wbReady", {31'b0, wbReady}, 1);
    // Asynchronous reset aborts a write
    wbValid = 1; rd = 9; wbData = 32'hCAFEBABE;
    step();
    wbValid = 0;
    chk("abort_bwe_before", {31'b0, bankWriteEnable}, 1);
    #2 reset = 1;
    #1;
    chk("abort_bwe", {31'b0, bankWriteEnable}, 0);
    chk("abort_bdi", bankDataIn, 0);
    chk("abort_brn", {28'b0, bankRegNum}, 0);
    step();
    reset = 0;
    step();
    chk("abort_reg9", regs[9], 32'hA5A50009);
    chk("abort_wbReady", {31'b0, wbReady}, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
